// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one word fetch at a time on a req/gnt
// handshake, captures the response and holds it until the consumer takes it.
// A response that never arrives locks the unit into a sticky error state.
module ifetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0C00,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:2] nextpc,
  output logic [31:2] pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:2] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // Last wait-counter value tolerated before the fetch is declared lost.
  localparam logic [4:0] WAIT_LAST = 5'(TIMEOUT - 1);

  state_t      state;
  logic [4:0]  wait_cnt;
  logic        req;

  // The request address is the current pc by construction.
  assign imem_addr = pc;
  assign imem_req  = req;

  // Fetch FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_REQ;
      pc          <= RESET_PC;
      instr       <= 32'h0000_0000;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      wait_cnt    <= 5'd0;
      req         <= 1'b1;
    end else begin
      case (state)
        ST_REQ: begin
          // Responses are not expected here; a stray rvalid is ignored.
          if (imem_gnt) begin
            state    <= ST_WAIT;
            req      <= 1'b0;
            wait_cnt <= 5'd0;
          end
        end

        ST_WAIT: begin
          // Entered the cycle after the grant, so rvalid is honoured here only.
          if (imem_rvalid) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= ST_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= ST_ERR;
            fetch_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 5'd1;
          end
        end

        ST_HOLD: begin
          // nextpc is sampled only on the edge the instruction is consumed.
          if (!stall) begin
            pc          <= nextpc;
            instr_valid <= 1'b0;
            state       <= ST_REQ;
            req         <= 1'b1;
          end
        end

        ST_ERR: begin
          // Absorbing until reset; outputs are re-asserted every cycle.
          req         <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end

        default: begin
          // Unreachable encoding: fail safe into the error state.
          state       <= ST_ERR;
          req         <= 1'b0;
          instr_valid <= 1'b0;
          fetch_err   <= 1'b1;
        end
      endcase
    end
  end

endmodule
